// File: rtl/rv_axi_mem_slave_pkg.sv
// Shared types for the reduced rv32 AXI responder: bus field widths, FSM states
// and the arbitration grant encoding.
package rv_axi_mem_slave_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [39:0] axi_addr_t;
  typedef logic [7:0]  axi_len_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD       = 2'd2,
    RD_DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

endpackage

// File: rtl/rv_axi_mem_slave_if.sv
// Reduced AXI bus (AW/W/AR/R, no B channel, no write strobes) between the rv32
// CPU-bus port and a memory responder.
interface rv_axi_mem_slave_if
  import rv_axi_mem_slave_pkg::*;
();

  axi_addr_t awaddr;
  axi_len_t  awlen;
  logic      awvalid;
  logic      awready;
  u32_t      wr_data;
  logic      wvalid;
  logic      wlast;
  logic      wready;
  axi_addr_t araddr;
  axi_len_t  arlen;
  logic      arvalid;
  logic      arready;
  u32_t      rd_data;
  logic      rvalid;
  logic      rlast;
  logic      rready;

  modport master (
    output awaddr, awlen, awvalid, wr_data, wvalid, wlast,
    output araddr, arlen, arvalid, rready,
    input  awready, wready, arready, rd_data, rvalid, rlast
  );

  modport slave (
    input  awaddr, awlen, awvalid, wr_data, wvalid, wlast,
    input  araddr, arlen, arvalid, rready,
    output awready, wready, arready, rd_data, rvalid, rlast
  );

endinterface

// File: rtl/rv_axi_mem_slave_bram.sv
// Single-port 2^AW x 32 word RAM: synchronous write, registered 1-cycle read.
// Written to infer a block RAM.
module rv_axi_bram
  import rv_axi_mem_slave_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  u32_t          wdata,
  output u32_t          rdata
);

  u32_t mem [2**AW];

  // NOTE: neither the array nor the read register has a reset; adding one
  // would stop the tools from mapping this onto a block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/rv_axi_mem_slave.sv
// AXI responder for the rv32 CPU-bus port: one INCR burst at a time against an
// on-chip word RAM, round-robin between pending write and read bursts.
module rv_axi_mem_slave
  import rv_axi_mem_slave_pkg::*;
#(
  parameter int AW      = 14,
  parameter int RD_SKID = 2
) (
  input  logic                aclk,
  input  logic                arst_n,
  rv_axi_mem_slave_if.slave   axi,
  output logic                busy,
  output logic                err_wlast
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WR       = WR;
  localparam logic [1:0] ST_RD       = RD;
  localparam logic [1:0] ST_RD_DRAIN = RD_DRAIN;

  logic [1:0]    state;
  gnt_e          last_gnt;
  logic [AW-1:0] addr;
  axi_len_t      cnt;

  logic idle_ok, gnt_wr, gnt_rd, wr_beat, rd_issue;
  logic inflight, inflight_last;
  u32_t ram_rdata;

  // Read skid buffer; the RAM output register acts as a bypass ahead of it.
  u32_t       fifo_data [RD_SKID];
  logic       fifo_last [RD_SKID];
  logic       wr_ptr, rd_ptr;
  logic [1:0] occ;
  logic       pop, push, pop_fifo;
  u32_t       head_data;
  logic       head_last;
  logic       rvalid_int;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.awaddr[39:AW+2], axi.awaddr[1:0],
                              axi.araddr[39:AW+2], axi.araddr[1:0]};

  // NOTE: the ready strobes are combinational off the valids, so they are also
  // qualified by arst_n to read 0 for the whole time reset is held.
  assign idle_ok  = (state == ST_IDLE) && arst_n;
  assign gnt_wr   = idle_ok && axi.awvalid && (!axi.arvalid || last_gnt == GNT_RD);
  assign gnt_rd   = idle_ok && axi.arvalid && !gnt_wr;
  assign wr_beat  = (state == ST_WR) && axi.wvalid;
  assign rd_issue = (state == ST_RD) && (({1'b0, occ} + {2'b00, inflight}) < 3'(RD_SKID));

  assign rvalid_int = (occ != 2'd0) || inflight;
  assign head_data  = (occ != 2'd0) ? fifo_data[rd_ptr] : ram_rdata;
  assign head_last  = (occ != 2'd0) ? fifo_last[rd_ptr] : inflight_last;
  assign pop        = rvalid_int && axi.rready;
  assign pop_fifo   = pop && (occ != 2'd0);
  // Returning RAM data is buffered unless it leaves through the bypass this cycle.
  assign push       = inflight && !((occ == 2'd0) && pop);

  assign axi.awready = gnt_wr;
  assign axi.arready = gnt_rd;
  assign axi.wready  = (state == ST_WR);
  assign axi.rvalid  = rvalid_int;
  assign axi.rd_data = rvalid_int ? head_data : '0;
  assign axi.rlast   = rvalid_int && head_last;
  assign busy        = (state != ST_IDLE);

  rv_axi_bram #(.AW(AW)) u_bram (
    .clk   (aclk),
    .we    (wr_beat),
    .re    (rd_issue),
    .addr  (addr),
    .wdata (axi.wr_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= ST_IDLE;
      last_gnt      <= GNT_RD;
      addr          <= '0;
      cnt           <= '0;
      err_wlast     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && (cnt == 8'd0);
      case (state)
        ST_IDLE: begin
          if (gnt_wr) begin
            addr     <= axi.awaddr[AW+1:2];
            cnt      <= axi.awlen;
            last_gnt <= GNT_WR;
            state    <= ST_WR;
          end else if (gnt_rd) begin
            addr     <= axi.araddr[AW+1:2];
            cnt      <= axi.arlen;
            last_gnt <= GNT_RD;
            state    <= ST_RD;
          end
        end
        ST_WR: begin
          if (wr_beat) begin
            addr <= addr + AW'(1);
            cnt  <= cnt - 8'd1;
            // The beat count alone ends the burst; wlast is only audited.
            if (axi.wlast != (cnt == 8'd0)) err_wlast <= 1'b1;
            if (cnt == 8'd0) state <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (rd_issue) begin
            addr <= addr + AW'(1);
            cnt  <= cnt - 8'd1;
            if (cnt == 8'd0) state <= ST_RD_DRAIN;
          end
        end
        ST_RD_DRAIN: begin
          if (pop && head_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push)     wr_ptr <= ~wr_ptr;
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_rdata;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

endmodule

// File: tb/tb_rv_axi_mem_slave.sv
// Self-checking bench for rv_axi_mem_slave: table-driven write/read-back bursts
// with a read scoreboard, plus hand-written arbitration, wrap and reset sequences.
module tb_rv_axi_mem_slave;
  import rv_axi_mem_slave_pkg::*;

  localparam int AW   = 14;
  localparam int MASK = (1 << AW) - 1;

  typedef struct {
    u32_t data;
    logic last;
  } exp_t;

  typedef struct {
    axi_addr_t addr;
    int        len;
    u32_t      base;
    u32_t      step;
    int        wlast_beat;
    int        rr_mode;
    logic      exp_err;
  } vec_t;

  logic aclk;
  logic arst_n;
  logic busy;
  logic err_wlast;
  int   cyc;
  int   vec_cnt;
  int   err_cnt;

  u32_t mdl  [2**AW];
  u32_t wbuf [256];
  exp_t sb   [$];
  vec_t tbl  [5];

  rv_axi_mem_slave_if bus();

  rv_axi_mem_slave #(.AW(AW), .RD_SKID(2)) dut (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .axi       (bus),
    .busy      (busy),
    .err_wlast (err_wlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: got no handshake, required one within the cycle budget (cycle %0d)", name, cyc);
  endtask

  function automatic int word_of(input axi_addr_t a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic do_write(input axi_addr_t a, input int len, input int wlast_beat);
    int n;
    @(negedge aclk);
    bus.awaddr  = a;
    bus.awlen   = axi_len_t'(len);
    bus.awvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.awready && n < 100) begin
      @(negedge aclk); #1; n++;
    end
    if (!bus.awready) begin
      fail_timeout("awready");
      bus.awvalid = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      @(negedge aclk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b1;
      bus.wr_data = wbuf[i];
      bus.wlast   = (i == wlast_beat);
      #1;
      if (i == 0) check("wready_at_T+1", bus.wready, 1);
      n = 0;
      while (!bus.wready && n < 100) begin
        @(negedge aclk); #1; n++;
      end
      if (!bus.wready) begin
        fail_timeout("wready");
        bus.wvalid = 1'b0;
        return;
      end
      mdl[(word_of(a) + i) & MASK] = wbuf[i];
    end
    @(negedge aclk);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    #1;
    check("busy_after_write", busy, 0);
  endtask

  // rr_mode: 0 = rready always high, 1 = toggling 1,0,1,0..., 2 = random.
  task automatic do_read(input axi_addr_t a, input int len, input int rr_mode, input int abort_beat);
    int   n, t_hs, beat;
    logic stalled, seen;
    u32_t hold_d;
    logic hold_l;
    exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.data = mdl[(word_of(a) + i) & MASK];
      e.last = (i == len);
      sb.push_back(e);
    end
    @(negedge aclk);
    bus.araddr  = a;
    bus.arlen   = axi_len_t'(len);
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    #1;
    n = 0;
    while (!bus.arready && n < 100) begin
      @(negedge aclk); #1; n++;
    end
    if (!bus.arready) begin
      fail_timeout("arready");
      bus.arvalid = 1'b0;
      sb.delete();
      return;
    end
    t_hs = cyc; beat = 0; stalled = 1'b0; seen = 1'b0; hold_d = '0; hold_l = 1'b0; n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge aclk);
      bus.arvalid = 1'b0;
      case (rr_mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (n % 2 == 0);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      n++;
      if (stalled) begin
        check("rvalid_held", bus.rvalid, 1);
        check("rd_data_held", bus.rd_data, hold_d);
        check("rlast_held", bus.rlast, hold_l);
      end
      stalled = 1'b0;
      if (bus.rvalid) begin
        if (!seen) begin
          check("first_rvalid_latency", cyc - t_hs, 2);
          seen = 1'b1;
        end
        if (beat == abort_beat) begin
          arst_n      = 1'b0;
          bus.arvalid = 1'b1;
          #1;
          check("rst_rvalid", bus.rvalid, 0);
          check("rst_busy", busy, 0);
          check("rst_arready", bus.arready, 0);
          check("rst_rd_data", bus.rd_data, 0);
          sb.delete();
          return;
        end
        if (bus.rready) begin
          e = sb.pop_front();
          check("rd_data", bus.rd_data, e.data);
          check("rlast", bus.rlast, e.last);
          if (rr_mode == 0 && e.last) check("last_beat_cycle", cyc - t_hs, 2 + len);
          beat++;
        end else begin
          stalled = 1'b1;
          hold_d  = bus.rd_data;
          hold_l  = bus.rlast;
        end
      end
    end
    if (sb.size() != 0) begin
      fail_timeout("read_beats");
      sb.delete();
    end
    @(negedge aclk);
    bus.rready = 1'b0;
    #1;
    check("busy_after_read", busy, 0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;

    tbl[0] = '{40'h00_0010_1000, 15,  32'h0000_0000, 32'h0000_0001, 15,  1, 1'b0};
    tbl[1] = '{40'h00_0020_0100, 15,  32'h1000_0000, 32'h0000_0011, 15,  0, 1'b0};
    tbl[2] = '{40'h00_0000_3F00, 255, 32'h5A5A_0000, 32'h0000_0003, 255, 0, 1'b0};
    tbl[3] = '{40'h00_0030_0200, 6,   32'h0BAD_0000, 32'h0000_0007, 6,   2, 1'b0};
    tbl[4] = '{40'h00_0040_0400, 3,   32'hE000_0000, 32'h0000_0001, 1,   0, 1'b1};

    // Reset with both address channels already requesting.
    arst_n      = 1'b0;
    bus.awaddr  = 40'h00_0010_0040;
    bus.awlen   = 8'd0;
    bus.awvalid = 1'b1;
    bus.araddr  = 40'h00_0010_0040;
    bus.arlen   = 8'd0;
    bus.arvalid = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    bus.wvalid  = 1'b1;
    bus.wlast   = 1'b1;
    bus.rready  = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    check("reset_awready", bus.awready, 0);
    check("reset_arready", bus.arready, 0);
    check("reset_wready", bus.wready, 0);
    check("reset_rvalid", bus.rvalid, 0);
    check("reset_rlast", bus.rlast, 0);
    check("reset_rd_data", bus.rd_data, 0);
    check("reset_busy", busy, 0);
    check("reset_err_wlast", err_wlast, 0);

    // First grant after reset goes to the write; the read follows round-robin.
    @(negedge aclk);
    arst_n = 1'b1;
    #1;
    check("sim_awready_first", bus.awready, 1);
    check("sim_arready_held", bus.arready, 0);
    @(negedge aclk);
    bus.awaddr = 40'h00_0010_0080;
    #1;
    check("sim_wready", bus.wready, 1);
    check("sim_aw_held_in_wr", bus.awready, 0);
    check("sim_ar_held_in_wr", bus.arready, 0);
    mdl[word_of(40'h00_0010_0040)] = 32'hDEAD_BEEF;
    @(negedge aclk);
    bus.wr_data = 32'hCAFE_F00D;
    #1;
    check("sim_arready_rr", bus.arready, 1);
    check("sim_awready_rr", bus.awready, 0);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    #1;
    check("sim_aw_held_in_rd", bus.awready, 0);
    check("sim_rvalid_T+1", bus.rvalid, 0);
    @(negedge aclk);
    #1;
    check("sim_rvalid_T+2", bus.rvalid, 1);
    check("sim_rd_data", bus.rd_data, 32'hDEAD_BEEF);
    check("sim_rlast", bus.rlast, 1);
    @(negedge aclk);
    #1;
    check("sim_awready_second", bus.awready, 1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    #1;
    check("sim_wready_second", bus.wready, 1);
    mdl[word_of(40'h00_0010_0080)] = 32'hCAFE_F00D;
    @(negedge aclk);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    #1;
    check("sim_busy_idle", busy, 0);
    check("sim_err_wlast", err_wlast, 0);
    do_read(40'h00_0010_0080, 0, 0, -1);

    // Table-driven write then read-back bursts.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i <= tbl[v].len; i++) wbuf[i] = tbl[v].base + u32_t'(i) * tbl[v].step;
      do_write(tbl[v].addr, tbl[v].len, tbl[v].wlast_beat);
      check("err_wlast_vec", err_wlast, tbl[v].exp_err);
      do_read(tbl[v].addr, tbl[v].len, tbl[v].rr_mode, -1);
    end

    // Write across the top of the RAM, then read the wrapped beats from word 0.
    wbuf[0] = 32'hAAAA_000A;
    wbuf[1] = 32'hBBBB_000B;
    wbuf[2] = 32'hCCCC_000C;
    wbuf[3] = 32'hDDDD_000D;
    do_write(40'h12_0000_0000 | 40'((2**AW - 2) << 2), 3, 3);
    check("wrap_model_c", mdl[0], 32'hCCCC_000C);
    do_read(40'hFF_0000_0000, 1, 0, -1);

    // Reset during beat 5 of a 16-beat read, then a clean read afterwards.
    do_read(40'h00_0010_1000, 15, 0, 5);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    arst_n      = 1'b1;
    #1;
    check("post_rst_err_wlast", err_wlast, 0);
    check("post_rst_rvalid", bus.rvalid, 0);
    do_read(40'h00_0010_1000, 15, 0, -1);

    repeat (2) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
